// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: A - B one digit per clock, LSD first, sign-magnitude result.
// A negative raw difference is fixed up by a second serial ten's-complement pass.
//
// state  | meaning
// S_IDLE | waiting for i_start; outputs hold last result
// S_SUB  | one digit of a - b - borrow per cycle
// S_NEG  | one digit of 0 - r - borrow per cycle (ten's complement)
// S_DONE | single-cycle result-valid pulse
module bcd_serial_subtractor #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   input  logic [4*DIGITS-1:0]   i_a,
   input  logic [4*DIGITS-1:0]   i_b,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [4*DIGITS-1:0]   o_diff,
   output logic                  o_neg,
   output logic                  o_invalid
);
   localparam int W  = 4 * DIGITS;
   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_SUB, S_NEG, S_DONE} state_t;

   state_t          r_state;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_res;
   logic [CW-1:0]   r_cnt;
   logic            r_br;
   logic            r_busy;
   logic            r_done;
   logic [W-1:0]    r_diff;
   logic            r_neg;
   logic            r_invalid;

   logic            w_bad;
   logic [3:0]      w_x;
   logic [3:0]      w_y;
   logic signed [4:0] w_t;
   logic [3:0]      w_r;
   logic            w_borrow;
   logic [W+3:0]    w_cat;
   logic [W-1:0]    w_res_sh;

   always_comb begin
      w_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (i_a[4*i +: 4] > 4'd9 || i_b[4*i +: 4] > 4'd9) w_bad = 1'b1;
      end
   end

   // Operands shift right each cycle so the working digit is always at [3:0].
   always_comb begin
      w_x      = (r_state == S_SUB) ? r_a[3:0] : 4'd0;
      w_y      = (r_state == S_SUB) ? r_b[3:0] : r_res[3:0];
      w_t      = $signed({1'b0, w_x}) - $signed({1'b0, w_y}) - $signed({4'b0000, r_br});
      w_borrow = w_t[4];
      w_r      = w_borrow ? (w_t[3:0] + 4'd10) : w_t[3:0];
      w_cat    = {w_r, r_res};
      w_res_sh = w_cat[W+3:4];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_res     <= '0;
         r_cnt     <= '0;
         r_br      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_diff    <= '0;
         r_neg     <= 1'b0;
         r_invalid <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_a       <= i_a;
                  r_b       <= i_b;
                  r_diff    <= '0;
                  r_neg     <= 1'b0;
                  r_invalid <= 1'b0;
                  if (w_bad) begin
                     r_invalid <= 1'b1;
                     r_done    <= 1'b1;
                     r_state   <= S_DONE;
                  end else begin
                     r_br    <= 1'b0;
                     r_cnt   <= LAST;
                     r_res   <= '0;
                     r_busy  <= 1'b1;
                     r_state <= S_SUB;
                  end
               end
            end
            S_SUB: begin
               r_a   <= r_a >> 4;
               r_b   <= r_b >> 4;
               r_res <= w_res_sh;
               r_br  <= w_borrow;
               if (r_cnt == '0) begin
                  if (w_borrow) begin
                     r_br    <= 1'b0;
                     r_cnt   <= LAST;
                     r_state <= S_NEG;
                  end else begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_diff  <= w_res_sh;
                     r_state <= S_DONE;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_NEG: begin
               r_res <= w_res_sh;
               r_br  <= w_borrow;
               if (r_cnt == '0) begin
                  r_br    <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_diff  <= w_res_sh;
                  r_neg   <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_diff    = r_diff;
   assign o_neg     = r_neg;
   assign o_invalid = r_invalid;
endmodule

// File: doc/bcd_serial_subtractor.md
# bcd_serial_subtractor

Digit-serial multi-digit BCD subtractor that computes A − B one decimal digit per clock, LSD first, and returns a sign-magnitude BCD result. It is the inverse datapath to the BCD adder chain. It is used where area matters more than latency, such as the ALU subtract path and the decimal counter down-count. Operands are accepted with a start pulse and the result is flagged with a one-cycle done pulse.

## Interface
- DIGITS, default 4: number of BCD digits per operand, minimum 1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  request; sampled only in IDLE.
- a  in  4*DIGITS  minuend, packed BCD; digit i is a[4i+3:4i], and digit 0 is least significant.
- b  in  4*DIGITS  subtrahend, packed BCD, same packing as a.
- busy  out  1  high while a subtraction is in progress (SUB or NEG state).
- done  out  1  one-cycle pulse marking that the result is valid.
- diff  out  4*DIGITS  magnitude |A − B| in packed BCD.
- neg  out  1  set when A < B.
- invalid  out  1  set when any digit of a or b was greater than 9 at start.

## Operation
- States: IDLE, SUB, NEG, DONE.
- IDLE, start=1:
  - Latch a and b.
  - If any latched digit is greater than 9, go to DONE with invalid=1.
  - Otherwise clear borrow, clear the digit index, and go to SUB.
- SUB, one digit per cycle:
  - t = a_i − b_i − br. If t < 0, then r_i = t + 10 and br = 1; else r_i = t and br = 0.
  - After digit DIGITS−1: if br=1, clear br and the index and go to NEG. If br=0, go to DONE.
- NEG, one digit per cycle: ten's complement of r.
  - t = 0 − r_i − br, with the same +10 and borrow rule as SUB.
  - After the last digit, go to DONE with neg=1.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - diff, neg and invalid load on entry to DONE.
  - They hold until the next start is accepted.
- Output rules:
  - diff is never updated with intermediate values.
  - On an invalid request, diff = 0 and neg = 0.
  - Equal operands give diff = 0 with neg = 0. Negative zero is never produced.
- Arithmetic: each digit is 4 bits, and the working value is 5 bits signed. Every r_i is always in 0..9.
- start is ignored in SUB, NEG and DONE. There is no queueing.
- a and b may change freely after the start cycle.

## Timing
- Reset (rst_n=0):
  - Immediate, asynchronous: state = IDLE.
  - busy = 0, done = 0, diff = 0, neg = 0, invalid = 0. Internal borrow and index are cleared.
  - Reset mid-operation aborts the operation and no done is produced.
- Deassertion of reset is synchronised externally; the first active edge after deassertion may sample start.
- Cycle timeline (cycle 0 = the cycle in which start is sampled in IDLE):
  - Cycles 1..DIGITS: SUB, busy = 1.
  - A ≥ B: DONE in cycle DIGITS+1. Latency is DIGITS+1 cycles.
  - A < B: NEG in cycles DIGITS+1..2*DIGITS, then DONE in cycle 2*DIGITS+1.
  - Invalid request: DONE in cycle 1, busy never asserts.
- In the DONE cycle, busy = 0. The earliest next start is sampled in the cycle after done.
- Throughput for back-to-back requests: one operation per DIGITS+2 cycles for non-negative results, or 2*DIGITS+2 cycles for negative results.

## Test plan
- a=4321, b=1234, start=1 in cycle 0: done in cycle 5 with diff=3087, neg=0, invalid=0; busy high in cycles 1–4.
- a=0012, b=0047: intermediate r=9965, then done in cycle 9 with diff=0035, neg=1; busy high in cycles 1–8.
- Edge cases:
  - a=0000, b=0001 gives diff=0001, neg=1.
  - a=5000, b=5000 gives diff=0000, neg=0.
  - a=9999, b=0000 gives diff=9999, neg=0.
- a=00A3, b=0001: done in cycle 1 with invalid=1, diff=0000, neg=0; busy never high.
- Reset and start-while-busy:
  - Start a=4321/b=1234, then assert rst_n=0 in cycle 2. All outputs go to 0 immediately and no done pulse occurs.
  - A fresh start after reset gives correct results.
  - Pulsing start with new operands in cycle 3 of another run has no effect on that run's result.
- Back-to-back: issue a new start in the cycle after done. diff and neg from the first run hold until that start is accepted, and the second run's result appears at the correct latency.
